// File: rtl/memory_stage_pkg.sv
// Shared types and constants for the memory stage: FSM state encoding,
// write-back select codes, default data width and register-index width.
package memory_stage_pkg;

  localparam int unsigned DATA_W     = 16;
  localparam int unsigned REG_ADDR_W = 3;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    WB_ALU     = 2'b00,
    WB_MEM     = 2'b01,
    WB_IMM     = 2'b10,
    WB_ALU_ALT = 2'b11
  } wb_sel_t;

endpackage

// File: rtl/mem_access_fsm.sv
// Data-memory handshake FSM: issues the request, holds it while the memory
// is busy, raises stall upstream and (with MEM_TIMEOUT_EN defined) aborts an
// access that waits too long, flagging a sticky timeout_err.
module mem_access_fsm #(
  parameter int unsigned DATA_W  = memory_stage_pkg::DATA_W,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [DATA_W-1:0] addr_in,
  input  logic [DATA_W-1:0] wdata_in,
  input  logic              dmem_ready,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  output logic              stall,
  output logic              timeout_abort,
  output logic              timeout_err
);
  import memory_stage_pkg::*;

  state_t              state_reg, state_next;
  logic [DATA_W-1:0]   addr_reg;
  logic [DATA_W-1:0]   wdata_reg;
  logic                we_reg;
  logic                timeout_hit;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Capture the request fields while idle so they stay frozen during ACCESS
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_reg  <= '0;
      wdata_reg <= '0;
      we_reg    <= 1'b0;
    end else if (state_reg == IDLE) begin
      addr_reg  <= addr_in;
      wdata_reg <= wdata_in;
      we_reg    <= mem_write;
    end
  end

`ifdef MEM_TIMEOUT_EN
  // Counter width must hold TIMEOUT itself (the abort cycle still increments)
  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] wait_cnt_reg;
  logic             timeout_err_reg;

  // The issuing IDLE cycle was already one wait, so TIMEOUT waits have
  // elapsed once the ACCESS counter reaches TIMEOUT-1.
  assign timeout_hit = (wait_cnt_reg == CNT_W'(TIMEOUT - 1));
  assign timeout_err = timeout_err_reg;

  // Count ACCESS cycles spent without ready; cleared whenever idle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                  wait_cnt_reg <= '0;
    else if (state_reg != ACCESS) wait_cnt_reg <= '0;
    else if (!dmem_ready)        wait_cnt_reg <= wait_cnt_reg + CNT_W'(1);
  end

  // Sticky abort flag, cleared only by reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)             timeout_err_reg <= 1'b0;
    else if (timeout_abort) timeout_err_reg <= 1'b1;
  end
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Next state and handshake outputs; reset forces everything quiet at once
  always_comb begin
    state_next    = state_reg;
    dmem_req      = 1'b0;
    dmem_we       = 1'b0;
    dmem_addr     = addr_in;
    dmem_wdata    = wdata_in;
    stall         = 1'b0;
    timeout_abort = 1'b0;
    if (reset) begin
      case (state_reg)
        IDLE: begin
          if (mem_read || mem_write) begin
            dmem_req = 1'b1;
            dmem_we  = mem_write;   // store wins when both are requested
            if (!dmem_ready) begin
              stall      = 1'b1;
              state_next = ACCESS;
            end
          end
        end
        ACCESS: begin
          dmem_addr  = addr_reg;
          dmem_wdata = wdata_reg;
          if (dmem_ready) begin
            dmem_req   = 1'b1;
            dmem_we    = we_reg;
            state_next = IDLE;
          end else if (timeout_hit) begin
            timeout_abort = 1'b1;
            state_next    = IDLE;
          end else begin
            dmem_req = 1'b1;
            dmem_we  = we_reg;
            stall    = 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

endmodule

// File: rtl/memory_stage.sv
// Pipeline MEM stage: drives the data-memory handshake through
// mem_access_fsm, selects the write-back value and holds the MEM/WB register.
// Optional access timeout enabled by defining MEM_TIMEOUT_EN.
module memory_stage #(
  parameter int unsigned DATA_W  = memory_stage_pkg::DATA_W,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [DATA_W-1:0]                     alu_result_from_ex,
  input  logic                                  reg_write_from_ex,
  input  logic [memory_stage_pkg::REG_ADDR_W-1:0] reg_write_address_from_ex,
  input  logic [DATA_W-1:0]                     sign_extend_from_ex,
  input  logic [1:0]                            write_back_select_from_ex,
  input  logic [DATA_W-1:0]                     read_data2_from_ex,
  input  logic                                  mem_read_from_ex,
  input  logic                                  mem_write_from_ex,
  output logic                                  dmem_req,
  output logic                                  dmem_we,
  output logic [DATA_W-1:0]                     dmem_addr,
  output logic [DATA_W-1:0]                     dmem_wdata,
  input  logic [DATA_W-1:0]                     dmem_rdata,
  input  logic                                  dmem_ready,
  output logic                                  stall,
  output logic                                  reg_write_to_wb,
  output logic [memory_stage_pkg::REG_ADDR_W-1:0] reg_write_address_to_wb,
  output logic [DATA_W-1:0]                     write_back_data_to_wb,
  output logic                                  timeout_err
);
  import memory_stage_pkg::*;

  logic                  timeout_abort;
  logic                  wb_load;
  logic [DATA_W-1:0]     wb_data_next;
  logic                  reg_write_reg;
  logic [REG_ADDR_W-1:0] reg_write_address_reg;
  logic [DATA_W-1:0]     write_back_data_reg;

  mem_access_fsm #(
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT)
  ) u_fsm (
    .clk           (clk),
    .reset         (reset),
    .mem_read      (mem_read_from_ex),
    .mem_write     (mem_write_from_ex),
    .addr_in       (alu_result_from_ex),
    .wdata_in      (read_data2_from_ex),
    .dmem_ready    (dmem_ready),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_addr     (dmem_addr),
    .dmem_wdata    (dmem_wdata),
    .stall         (stall),
    .timeout_abort (timeout_abort),
    .timeout_err   (timeout_err)
  );

  // Write-back source select; memory data is taken in the completion cycle
  always_comb begin
    wb_data_next = alu_result_from_ex;
    case (write_back_select_from_ex)
      WB_MEM:  wb_data_next = dmem_rdata;
      WB_IMM:  wb_data_next = sign_extend_from_ex;
      default: wb_data_next = alu_result_from_ex;
    endcase
  end

  // An aborted access completes the stall but must not retire
  assign wb_load = !stall && !timeout_abort;

  // MEM/WB register: load the instruction, otherwise insert a bubble
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reg_write_reg         <= 1'b0;
      reg_write_address_reg <= '0;
      write_back_data_reg   <= '0;
    end else if (wb_load) begin
      reg_write_reg         <= reg_write_from_ex;
      reg_write_address_reg <= reg_write_address_from_ex;
      write_back_data_reg   <= wb_data_next;
    end else begin
      reg_write_reg <= 1'b0;
    end
  end

  assign reg_write_to_wb         = reg_write_reg;
  assign reg_write_address_to_wb = reg_write_address_reg;
  assign write_back_data_to_wb   = write_back_data_reg;

endmodule

// File: tb/tb_memory_stage.sv
// Directed testbench for memory_stage: table of single-cycle vectors plus
// hand-written multi-cycle sequences (wait-state store/load, reset during
// an access, long wait or timeout abort when MEM_TIMEOUT_EN is defined).
module tb_memory_stage;

  logic        clk;
  logic        reset;
  logic [15:0] alu;
  logic        rw;
  logic [2:0]  rwa;
  logic [15:0] sext;
  logic [1:0]  sel;
  logic [15:0] rd2;
  logic        mr;
  logic        mw;
  logic [15:0] rdata;
  logic        rdy;
  logic        dmem_req;
  logic        dmem_we;
  logic [15:0] dmem_addr;
  logic [15:0] dmem_wdata;
  logic        stall;
  logic        wb_rw;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;
  logic        timeout_err;

  int n_cmp = 0;
  int n_err = 0;

  memory_stage #(.DATA_W(16), .TIMEOUT(15)) dut (
    .clk                       (clk),
    .reset                     (reset),
    .alu_result_from_ex        (alu),
    .reg_write_from_ex         (rw),
    .reg_write_address_from_ex (rwa),
    .sign_extend_from_ex       (sext),
    .write_back_select_from_ex (sel),
    .read_data2_from_ex        (rd2),
    .mem_read_from_ex          (mr),
    .mem_write_from_ex         (mw),
    .dmem_req                  (dmem_req),
    .dmem_we                   (dmem_we),
    .dmem_addr                 (dmem_addr),
    .dmem_wdata                (dmem_wdata),
    .dmem_rdata                (rdata),
    .dmem_ready                (rdy),
    .stall                     (stall),
    .reg_write_to_wb           (wb_rw),
    .reg_write_address_to_wb   (wb_addr),
    .write_back_data_to_wb     (wb_data),
    .timeout_err               (timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic set_instr(input logic [15:0] a, input logic w, input logic [2:0] wa,
                           input logic [15:0] se, input logic [1:0] s, input logic [15:0] d2,
                           input logic r, input logic wr);
    alu = a; rw = w; rwa = wa; sext = se; sel = s; rd2 = d2; mr = r; mw = wr;
  endtask

  typedef struct {
    logic [15:0] alu;
    logic        rw;
    logic [2:0]  rwa;
    logic [15:0] sext;
    logic [1:0]  sel;
    logic [15:0] rd2;
    logic        mr;
    logic        mw;
    logic [15:0] rdata;
    logic        rdy;
    logic        exp_req;
    logic        exp_we;
    logic [15:0] exp_wb;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int stall_cnt;
    logic [2:0]  prev_addr;
    logic [15:0] prev_data;

    //           alu      rw    rwa   sext     sel    rd2      mr    mw    rdata    rdy   req   we    wb
    vecs[0] = '{16'h1234, 1'b1, 3'd5, 16'h0000, 2'b00, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h1234};
    vecs[1] = '{16'h1111, 1'b1, 3'd3, 16'hFFF0, 2'b10, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'hFFF0};
    vecs[2] = '{16'h0F0F, 1'b1, 3'd7, 16'h7777, 2'b11, 16'h0000, 1'b0, 1'b0, 16'h9999, 1'b0, 1'b0, 1'b0, 16'h0F0F};
    vecs[3] = '{16'h0040, 1'b1, 3'd2, 16'h0000, 2'b01, 16'h0000, 1'b1, 1'b0, 16'hBEEF, 1'b1, 1'b1, 1'b0, 16'hBEEF};
    vecs[4] = '{16'h0080, 1'b0, 3'd4, 16'h0000, 2'b00, 16'h5555, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h0080};
    vecs[5] = '{16'h2222, 1'b1, 3'd1, 16'h0000, 2'b00, 16'h0000, 1'b0, 1'b0, 16'hDEAD, 1'b1, 1'b0, 1'b0, 16'h2222};
    vecs[6] = '{16'h0090, 1'b0, 3'd6, 16'h0000, 2'b00, 16'h3C3C, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h0090};

    reset = 1'b0;
    set_instr(16'h0, 1'b0, 3'd0, 16'h0, 2'b00, 16'h0, 1'b0, 1'b0);
    rdata = 16'h0; rdy = 1'b0;
    #2;
    chk("reset_req",   {31'b0, dmem_req},    32'h0);
    chk("reset_stall", {31'b0, stall},       32'h0);
    chk("reset_wb_rw", {31'b0, wb_rw},       32'h0);
    chk("reset_wb_d",  {16'b0, wb_data},     32'h0);
    chk("reset_err",   {31'b0, timeout_err}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Single-cycle vectors: none of these may stall
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      set_instr(vecs[i].alu, vecs[i].rw, vecs[i].rwa, vecs[i].sext, vecs[i].sel,
                vecs[i].rd2, vecs[i].mr, vecs[i].mw);
      rdata = vecs[i].rdata; rdy = vecs[i].rdy;
      #1;
      chk($sformatf("v%0d_req", i),   {31'b0, dmem_req}, {31'b0, vecs[i].exp_req});
      chk($sformatf("v%0d_stall", i), {31'b0, stall},    32'h0);
      if (vecs[i].exp_req) begin
        chk($sformatf("v%0d_we", i),    {31'b0, dmem_we},  {31'b0, vecs[i].exp_we});
        chk($sformatf("v%0d_addr", i),  {16'b0, dmem_addr}, {16'b0, vecs[i].alu});
        if (vecs[i].exp_we)
          chk($sformatf("v%0d_wdata", i), {16'b0, dmem_wdata}, {16'b0, vecs[i].rd2});
      end
      @(posedge clk); #1;
      chk($sformatf("v%0d_wb_rw", i),   {31'b0, wb_rw},   {31'b0, vecs[i].rw});
      chk($sformatf("v%0d_wb_addr", i), {29'b0, wb_addr}, {29'b0, vecs[i].rwa});
      chk($sformatf("v%0d_wb_data", i), {16'b0, wb_data}, {16'b0, vecs[i].exp_wb});
    end
    prev_addr = vecs[6].rwa;
    prev_data = vecs[6].exp_wb;

    // 3-wait store; EX fields are disturbed mid-access to prove the request is held
    stall_cnt = 0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) begin
        set_instr(16'h0010, 1'b1, 3'd6, 16'h0, 2'b00, 16'hA5A5, 1'b0, 1'b1);
        rdy = 1'b0; rdata = 16'h0;
      end else if (c < 4) begin
        alu = 16'hFFFF; rd2 = 16'h0000;
      end else begin
        alu = 16'h0010; rd2 = 16'hA5A5; rdy = 1'b1;
      end
      #1;
      chk($sformatf("st_c%0d_req", c),   {31'b0, dmem_req},  32'h1);
      chk($sformatf("st_c%0d_we", c),    {31'b0, dmem_we},   32'h1);
      chk($sformatf("st_c%0d_addr", c),  {16'b0, dmem_addr}, 32'h0010);
      chk($sformatf("st_c%0d_wdata", c), {16'b0, dmem_wdata}, 32'hA5A5);
      chk($sformatf("st_c%0d_stall", c), {31'b0, stall},     (c < 4) ? 32'h1 : 32'h0);
      if (stall) stall_cnt++;
      @(posedge clk); #1;
      if (c < 4) begin
        chk($sformatf("st_c%0d_bubble", c), {31'b0, wb_rw},   32'h0);
        chk($sformatf("st_c%0d_hold_a", c), {29'b0, wb_addr}, {29'b0, prev_addr});
        chk($sformatf("st_c%0d_hold_d", c), {16'b0, wb_data}, {16'b0, prev_data});
      end else begin
        chk("st_done_rw",   {31'b0, wb_rw},   32'h1);
        chk("st_done_addr", {29'b0, wb_addr}, 32'h6);
        chk("st_done_data", {16'b0, wb_data}, 32'h0010);
      end
    end
    chk("st_stall_cycles", stall_cnt, 32'd3);

    // 2-wait load: data must come from the completion cycle
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (c == 1) begin
        set_instr(16'h0020, 1'b1, 3'd1, 16'h0, 2'b01, 16'h0, 1'b1, 1'b0);
        rdy = 1'b0; rdata = 16'h0BAD;
      end else if (c == 3) begin
        rdy = 1'b1; rdata = 16'hCAFE;
      end
      #1;
      chk($sformatf("ld_c%0d_we", c),    {31'b0, dmem_we}, 32'h0);
      chk($sformatf("ld_c%0d_stall", c), {31'b0, stall},   (c < 3) ? 32'h1 : 32'h0);
      @(posedge clk); #1;
      chk($sformatf("ld_c%0d_wb_rw", c), {31'b0, wb_rw}, (c < 3) ? 32'h0 : 32'h1);
    end
    chk("ld_wb_data", {16'b0, wb_data}, 32'hCAFE);
    chk("ld_wb_addr", {29'b0, wb_addr}, 32'h1);

    // Reset pulsed while in ACCESS
    @(negedge clk);
    set_instr(16'h0030, 1'b1, 3'd2, 16'h0, 2'b00, 16'h0, 1'b1, 1'b0);
    rdy = 1'b0;
    @(posedge clk); #1;
    chk("rst_acc_stall", {31'b0, stall}, 32'h1);
    #3;
    reset = 1'b0;
    #1;
    chk("rst_acc_req",     {31'b0, dmem_req}, 32'h0);
    chk("rst_acc_stall0",  {31'b0, stall},    32'h0);
    chk("rst_acc_wb_rw",   {31'b0, wb_rw},    32'h0);
    chk("rst_acc_wb_addr", {29'b0, wb_addr},  32'h0);
    chk("rst_acc_wb_data", {16'b0, wb_data},  32'h0);
    @(negedge clk);
    set_instr(16'h0, 1'b0, 3'd0, 16'h0, 2'b00, 16'h0, 1'b0, 1'b0);
    rdy = 1'b1;
    reset = 1'b1;
    #1;
    chk("post_rst_req", {31'b0, dmem_req}, 32'h0);
    @(posedge clk); #1;
    chk("post_rst_wb_rw", {31'b0, wb_rw}, 32'h0);
    @(negedge clk);
    rdy = 1'b0;

`ifdef MEM_TIMEOUT_EN
    // Ready never arrives: 15 stall cycles, then an abort cycle
    stall_cnt = 0;
    for (int c = 1; c <= 16; c++) begin
      if (c > 1) @(negedge clk);
      if (c == 1) set_instr(16'h0050, 1'b1, 3'd4, 16'h0, 2'b01, 16'h0, 1'b1, 1'b0);
      #1;
      if (c <= 15) begin
        if (stall !== 1'b1 || dmem_req !== 1'b1)
          chk($sformatf("to_c%0d_wait", c), {30'b0, stall, dmem_req}, 32'h3);
        else
          stall_cnt++;
      end else begin
        chk("to_abort_req",   {31'b0, dmem_req}, 32'h0);
        chk("to_abort_stall", {31'b0, stall},    32'h0);
      end
      @(posedge clk); #1;
      chk($sformatf("to_c%0d_wb_rw", c), {31'b0, wb_rw}, 32'h0);
    end
    chk("to_wait_cycles", stall_cnt, 32'd15);
    chk("to_err_set", {31'b0, timeout_err}, 32'h1);
`else
    // Without the timeout the access waits as long as needed
    stall_cnt = 0;
    for (int c = 1; c <= 21; c++) begin
      if (c > 1) @(negedge clk);
      if (c == 1) set_instr(16'h0050, 1'b1, 3'd4, 16'h0, 2'b01, 16'h0, 1'b1, 1'b0);
      if (c == 21) begin rdy = 1'b1; rdata = 16'h1357; end
      #1;
      if (stall) stall_cnt++;
      @(posedge clk); #1;
    end
    chk("long_wait_stalls", stall_cnt, 32'd20);
    chk("long_wait_wb_rw",  {31'b0, wb_rw},   32'h1);
    chk("long_wait_wb_d",   {16'b0, wb_data}, 32'h1357);
    chk("long_wait_err",    {31'b0, timeout_err}, 32'h0);
    rdy = 1'b0;
`endif

    // Next instruction proceeds normally
    @(negedge clk);
    set_instr(16'h4321, 1'b1, 3'd7, 16'h0, 2'b00, 16'h0, 1'b0, 1'b0);
    rdy = 1'b0;
    @(posedge clk); #1;
    chk("next_wb_rw",   {31'b0, wb_rw},   32'h1);
    chk("next_wb_data", {16'b0, wb_data}, 32'h4321);
`ifdef MEM_TIMEOUT_EN
    chk("next_err_sticky", {31'b0, timeout_err}, 32'h1);
`else
    chk("next_err_zero",   {31'b0, timeout_err}, 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
